// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and the
// counter-width helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, used to size the bit counter from WIDTH.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_bit.sv
// Single-bit full subtractor cell: difference and borrow-out of x - y - bin.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor: one full-subtractor cell reused over
// WIDTH cycles, LSB first, with a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-2:0]   r_sd;
  logic               r_bin;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;

  logic               w_d;
  logic               w_bout;
  logic [WIDTH-1:0]   w_sd_next;

  full_subtractor_bit u_bit (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // Work register only keeps the WIDTH-1 bits already produced; the final
  // result is the current bit concatenated on top of them.
  assign w_sd_next = {w_d, r_sd};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sd     <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_sd    <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sd  <= w_sd_next[WIDTH-1:1];
          r_bin <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff   <= w_sd_next;
            r_borrow <= w_bout;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_diff   <= '0;
          r_borrow <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors plus a transaction-level timing
// model checked every cycle, run on WIDTH=8 and WIDTH=13 instances.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  start_in;
  logic [63:0] a_in [2];
  logic [63:0] b_in [2];

  logic [1:0]  busy_o;
  logic [1:0]  done_o;
  logic [1:0]  borrow_o;
  logic [7:0]  diff8;
  logic [12:0] diff13;
  logic [63:0] diff_o [2];

  assign diff_o[0] = {56'd0, diff8};
  assign diff_o[1] = {51'd0, diff13};

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_in[0]),
    .a      (a_in[0][7:0]),
    .b      (b_in[0][7:0]),
    .busy   (busy_o[0]),
    .done   (done_o[0]),
    .diff   (diff8),
    .borrow (borrow_o[0])
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_in[1]),
    .a      (a_in[1][12:0]),
    .b      (b_in[1][12:0]),
    .busy   (busy_o[1]),
    .done   (done_o[1]),
    .diff   (diff13),
    .borrow (borrow_o[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 13;
  endfunction

  function automatic logic [63:0] mask(input int k);
    return (64'd1 << wid(k)) - 64'd1;
  endfunction

  // Transaction model: age counts edges since the accepting edge; -1 means idle.
  int          m_age    [2];
  logic [63:0] m_res    [2];
  logic        m_bres   [2];
  logic [63:0] m_diff   [2];
  logic        m_borrow [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_age[k]    <= -1;
        m_diff[k]   <= '0;
        m_borrow[k] <= 1'b0;
      end else if (m_age[k] < 0) begin
        if (start_in[k]) begin
          m_age[k]  <= 0;
          m_res[k]  <= ((a_in[k] & mask(k)) - (b_in[k] & mask(k))) & mask(k);
          m_bres[k] <= (a_in[k] & mask(k)) < (b_in[k] & mask(k));
        end
      end else if (m_age[k] == wid(k)) begin
        m_age[k] <= -1;
      end else begin
        m_age[k] <= m_age[k] + 1;
        if (m_age[k] + 1 == wid(k)) begin
          m_diff[k]   <= m_res[k];
          m_borrow[k] <= m_bres[k];
        end
      end
    end
  end

  logic chk_en = 1'b0;
  logic hold   = 1'b0;
  logic prev_hold = 1'b0;
  int   cyc = 0;
  int   last_done [2];
  int   nd [2];

  always @(negedge clk) begin
    cyc++;
    if (hold && !prev_hold) begin
      for (int k = 0; k < 2; k++) begin
        last_done[k] = -1;
        nd[k] = 0;
      end
    end
    prev_hold = hold;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy[%0d]", k),   {63'd0, busy_o[k]},   {63'd0, m_age[k] >= 0});
        check($sformatf("done[%0d]", k),   {63'd0, done_o[k]},   {63'd0, m_age[k] == wid(k)});
        check($sformatf("diff[%0d]", k),   diff_o[k],            m_diff[k]);
        check($sformatf("borrow[%0d]", k), {63'd0, borrow_o[k]}, {63'd0, m_borrow[k]});
        if (hold && done_o[k]) begin
          if (last_done[k] >= 0)
            check($sformatf("period[%0d]", k), 64'(cyc - last_done[k]), 64'(wid(k) + 2));
          last_done[k] = cyc;
          nd[k]++;
        end
      end
    end
  end

  task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] d, output logic br);
    @(negedge clk);
    a_in[k] = a;
    b_in[k] = b;
    start_in[k] = 1'b1;
    @(negedge clk);
    start_in[k] = 1'b0;
    lat = 0;
    while (!done_o[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    d  = diff_o[k];
    br = borrow_o[k];
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!done_o[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
    logic        br;
    string       name;
  } vec_t;

  initial begin
    int          lat;
    logic [63:0] d;
    logic        br;
    int          seen;
    int          guard;
    vec_t        vecs [4];

    rst_n = 1'b0;
    start_in = 2'b00;
    for (int k = 0; k < 2; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",   {63'd0, busy_o[0]},   64'd0);
    check("reset_done",   {63'd0, done_o[0]},   64'd0);
    check("reset_diff",   diff_o[0],            64'd0);
    check("reset_borrow", {63'd0, borrow_o[0]}, 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Basic op: latency and one-cycle done pulse
    do_op(0, 64'h5A, 64'h23, lat, d, br);
    check("t1_latency", 64'(lat), 64'd8);
    check("t1_diff",    d,        64'h37);
    check("t1_borrow",  {63'd0, br}, 64'd0);
    @(negedge clk);
    check("t1_done_width", {63'd0, done_o[0]}, 64'd0);

    vecs[0] = '{64'h00, 64'h01, 64'hFF, 1'b1, "t2_0m1"};
    vecs[1] = '{64'hFF, 64'hFF, 64'h00, 1'b0, "t3_ff"};
    vecs[2] = '{64'h80, 64'h7F, 64'h01, 1'b0, "t3_80m7f"};
    vecs[3] = '{64'h7F, 64'h80, 64'hFF, 1'b1, "t3_7fm80"};
    foreach (vecs[i]) begin
      do_op(0, vecs[i].a, vecs[i].b, lat, d, br);
      check({vecs[i].name, "_diff"},   d,           vecs[i].d);
      check({vecs[i].name, "_borrow"}, {63'd0, br}, {63'd0, vecs[i].br});
      check({vecs[i].name, "_lat"},    64'(lat),    64'd8);
    end

    do_op(1, 64'h0000, 64'h0001, lat, d, br);
    check("w13_diff",   d,           64'h1FFF);
    check("w13_borrow", {63'd0, br}, 64'd1);
    check("w13_lat",    64'(lat),    64'd13);

    // Start while busy is ignored
    @(negedge clk);
    a_in[0] = 64'h10; b_in[0] = 64'h01; start_in[0] = 1'b1;
    @(negedge clk);
    start_in[0] = 1'b0;
    @(negedge clk);
    a_in[0] = 64'hAA; b_in[0] = 64'h55; start_in[0] = 1'b1;
    @(negedge clk);
    start_in[0] = 1'b0; a_in[0] = '0; b_in[0] = '0;
    wait_done(0, lat);
    check("t4_done_seen", {63'd0, done_o[0]}, 64'd1);
    check("t4_diff",      diff_o[0],          64'h0F);
    repeat (3) @(negedge clk);
    check("t4_idle_after", {63'd0, busy_o[0]}, 64'd0);
    check("t4_diff_held",  diff_o[0],          64'h0F);

    // Reset during the fourth shift cycle aborts silently
    @(negedge clk);
    a_in[0] = 64'h5A; b_in[0] = 64'h23; start_in[0] = 1'b1;
    @(negedge clk);
    start_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy",   {63'd0, busy_o[0]},   64'd0);
    check("t5_done",   {63'd0, done_o[0]},   64'd0);
    check("t5_diff",   diff_o[0],            64'd0);
    check("t5_borrow", {63'd0, borrow_o[0]}, 64'd0);
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (done_o[0]) seen++;
    end
    check("t5_no_done", 64'(seen), 64'd0);
    do_op(0, 64'h09, 64'h03, lat, d, br);
    check("t5_new_diff",   d,           64'h06);
    check("t5_new_borrow", {63'd0, br}, 64'd0);

    // Back-to-back random ops with start held high on both widths
    repeat (3) @(negedge clk);
    hold = 1'b1;
    start_in = 2'b11;
    guard = 0;
    do begin
      a_in[0] = 64'($urandom_range(0, 255));
      b_in[0] = 64'($urandom_range(0, 255));
      a_in[1] = 64'($urandom_range(0, 8191));
      b_in[1] = 64'($urandom_range(0, 8191));
      @(negedge clk);
      guard++;
    end while ((nd[0] < 1000 || nd[1] < 1000) && guard < 20000);
    start_in = 2'b00;
    repeat (20) @(negedge clk);
    check("t6_ops_w8",  64'(nd[0] >= 1000), 64'd1);
    check("t6_ops_w13", 64'(nd[1] >= 1000), 64'd1);
    hold = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
